mips_mem_responder: RTL and testbench

- Memory-side responder for the multi-cycle MIPS core: accepts one word-aligned load/store request at a time from the core's memory port.
- Models a configurable number of wait states, then returns read data or a write acknowledge through a valid/ready response handshake.
- Serves as unified instruction/data memory for the non-pipelined core; the core initiates, this block responds.

---
 rtl/mips_mem_responder_pkg.sv | 37 +++
 rtl/mips_mem_responder_array.sv | 27 ++
 rtl/mips_mem_responder.sv | 151 +++++++++++++++
 tb/tb_mips_mem_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_responder_pkg.sv
// rtl/mips_mem_responder_pkg.sv - shared types and widths for the MIPS memory responder
package mips_mem_responder_pkg;

  localparam int MIPS_PC_WIDTH   = 32;
  localparam int MIPS_DATA_WIDTH = 32;
  localparam int MIPS_BE_WIDTH   = MIPS_DATA_WIDTH / 8;

  typedef logic [MIPS_PC_WIDTH-1:0]   mips_pc_t;
  typedef logic [MIPS_DATA_WIDTH-1:0] mips_data_t;
  typedef logic [MIPS_BE_WIDTH-1:0]   mips_be_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mips_mem_state_t;

  typedef struct packed {
    logic       we;
    mips_pc_t   addr;
    mips_data_t wdata;
    mips_be_t   be;
  } mips_mem_req_t;

  // Replace only the byte lanes whose enable bit is set.
  function automatic mips_data_t merge_bytes(input mips_data_t old_word,
                                             input mips_data_t new_word,
                                             input mips_be_t   be);
    mips_data_t res;
    res = old_word;
    for (int b = 0; b < MIPS_BE_WIDTH; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mips_mem_responder_array.sv
// rtl/mips_mem_responder_array.sv - single-port word memory, byte-enable write, registered read
module mips_mem_array
  import mips_mem_responder_pkg::*;
#(
  parameter int MEM_DEPTH_WORDS = 1024
) (
  input  logic                               clk,
  input  logic                               en,
  input  logic                               we,
  input  logic [MIPS_BE_WIDTH-1:0]           be,
  input  logic [$clog2(MEM_DEPTH_WORDS)-1:0] idx,
  input  logic [MIPS_DATA_WIDTH-1:0]         wdata,
  output logic [MIPS_DATA_WIDTH-1:0]         rdata
);

  // Storage is deliberately not reset so it maps onto a block RAM later.
  mips_data_t mem [MEM_DEPTH_WORDS];

  // One access per enabled cycle: merge enabled bytes on a write, latch the word on a read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[idx] <= merge_bytes(mem[idx], wdata, be);
      else    rdata    <= mem[idx];
    end
  end

endmodule

// File: rtl/mips_mem_responder.sv
// rtl/mips_mem_responder.sv - wait-state memory responder for the multi-cycle MIPS core (option: MIPS_MEM_PERF_EN)
module mips_mem_responder
  import mips_mem_responder_pkg::*;
#(
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int WAIT_STATES     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [MIPS_PC_WIDTH-1:0]   req_addr,
  input  logic [MIPS_DATA_WIDTH-1:0] req_wdata,
  input  logic [MIPS_BE_WIDTH-1:0]   req_be,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [MIPS_DATA_WIDTH-1:0] rsp_rdata,
  output logic                       rsp_err
`ifdef MIPS_MEM_PERF_EN
  ,
  output logic [31:0]                perf_loads,
  output logic [31:0]                perf_stores,
  output logic [31:0]                perf_errs
`endif
);

  localparam int       AW          = $clog2(MEM_DEPTH_WORDS);
  localparam mips_pc_t DEPTH_LIMIT = mips_pc_t'(MEM_DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  mips_mem_state_t state, state_n;
  logic [3:0]      cnt;
  mips_mem_req_t   req_q;
  mips_mem_req_t   cur_req;
  logic            rsp_err_q;
  logic            accept;
  logic            enter_resp;
  logic            handshake;
  logic            cur_err;
  logic [AW-1:0]   cur_idx;
  mips_data_t      arr_rdata;

  // With zero wait states the request is decoded on its acceptance cycle, so use the live inputs in IDLE.
  always_comb begin
    cur_req = req_q;
    if (state == IDLE) begin
      cur_req.we    = req_we;
      cur_req.addr  = req_addr;
      cur_req.wdata = req_wdata;
      cur_req.be    = req_be;
    end
  end

  assign cur_err   = (cur_req.addr[1:0] != 2'b00) || ((cur_req.addr >> 2) >= DEPTH_LIMIT);
  assign cur_idx   = cur_req.addr[AW+1:2];
  assign accept    = req_valid && req_ready;
  assign handshake = rsp_valid && rsp_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and handshake outputs; enter_resp marks the one cycle the memory is accessed.
  always_comb begin
    state_n    = state;
    enter_resp = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            state_n    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_n    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request capture, wait countdown and the registered error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 4'd0;
      req_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept) begin
        req_q <= cur_req;
        cnt   <= WAIT_LOAD;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp)     rsp_err_q <= cur_err;
      else if (handshake) rsp_err_q <= 1'b0;
    end
  end

  mips_mem_array #(
    .MEM_DEPTH_WORDS(MEM_DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .en   (enter_resp && !cur_err),
    .we   (cur_req.we),
    .be   (cur_req.be),
    .idx  (cur_idx),
    .wdata(cur_req.wdata),
    .rdata(arr_rdata)
  );

  // Read data only leaves the block for a successful load; the array output is otherwise masked.
  assign rsp_rdata = (rsp_valid && !req_q.we && !rsp_err_q) ? arr_rdata : '0;
  assign rsp_err   = rsp_err_q;

`ifdef MIPS_MEM_PERF_EN
  // Saturating per-type counters bumped on the response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_errs   <= '0;
    end else if (handshake) begin
      if (rsp_err_q) begin
        if (perf_errs != 32'hFFFF_FFFF) perf_errs <= perf_errs + 32'd1;
      end else if (req_q.we) begin
        if (perf_stores != 32'hFFFF_FFFF) perf_stores <= perf_stores + 32'd1;
      end else begin
        if (perf_loads != 32'hFFFF_FFFF) perf_loads <= perf_loads + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mips_mem_responder.sv
// tb/tb_mips_mem_responder.sv - scoreboard bench for mips_mem_responder (WAIT_STATES 2 and 0)
module tb_mips_mem_responder;

  localparam int WS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;
  logic        req_valid0, req_ready0, req_we0, rsp_valid0, rsp_ready0, rsp_err0;
  logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
  logic [3:0]  req_be0;
`ifdef MIPS_MEM_PERF_EN
  logic [31:0] pl, ps, pe, pl0, ps0, pe0;
`endif

  mips_mem_responder #(.MEM_DEPTH_WORDS(1024), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef MIPS_MEM_PERF_EN
    , .perf_loads(pl), .perf_stores(ps), .perf_errs(pe)
`endif
  );

  mips_mem_responder #(.MEM_DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0), .rsp_valid(rsp_valid0),
    .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
`ifdef MIPS_MEM_PERF_EN
    , .perf_loads(pl0), .perf_stores(ps0), .perf_errs(pe0)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // due = edge index after which rsp_valid must first be seen
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;
  exp_t q2[$];
  exp_t q0[$];
  int   hs_edge2 = 0;
  logic prev_v2  = 1'b0;
  logic prev_v0  = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor for the WAIT_STATES=2 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v2 = 1'b0;
    end else begin
      if (rsp_valid) begin
        chk("req_ready_low_in_resp", {31'd0, req_ready}, 32'd0);
        if (q2.size() == 0) begin
          flag("unexpected_rsp");
        end else begin
          if (!prev_v2) chk("latency", cyc, q2[0].due);
          chk("rsp_rdata", rsp_rdata, q2[0].rdata);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, q2[0].err});
          if (rsp_ready) begin
            void'(q2.pop_front());
            hs_edge2 = cyc + 1;
          end
        end
      end
      prev_v2 = rsp_valid;
    end
  end

  // Monitor for the WAIT_STATES=0 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v0 = 1'b0;
    end else begin
      if (rsp_valid0) begin
        if (q0.size() == 0) begin
          flag("unexpected_rsp0");
        end else begin
          if (!prev_v0) chk("latency0", cyc, q0[0].due);
          chk("rsp_rdata0", rsp_rdata0, q0[0].rdata);
          chk("rsp_err0", {31'd0, rsp_err0}, {31'd0, q0[0].err});
          if (rsp_ready0) void'(q0.pop_front());
        end
      end
      prev_v0 = rsp_valid0;
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                        input bit push, output int acc);
    logic r;
    exp_t e;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    acc = -1;
    for (int i = 0; i < 60 && acc < 0; i++) begin
      @(negedge clk);
      r = req_ready;
      @(posedge clk);
      #1;
      if (r) begin
        acc = cyc;
        if (push) begin
          e.rdata = exp_rd;
          e.err   = exp_err;
          e.due   = cyc + WS;
          q2.push_back(e);
        end
      end
    end
    req_valid = 1'b0;
    if (acc < 0) flag($sformatf("req_timeout addr=%h", addr));
  endtask

  task automatic drain2();
    for (int i = 0; i < 100 && q2.size() > 0; i++) @(negedge clk);
    if (q2.size() > 0) flag("drain_timeout");
  endtask

  logic [31:0] v_addr [5] = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h0};
  logic [31:0] v_data [5] = '{32'h0102_0304, 32'hA5A5_A5A5, 32'h0, 32'h0, 32'h0};
  logic        v_we   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] v_exp  [5] = '{32'h0, 32'h0, 32'h0102_0304, 32'hA5A5_A5A5, 32'h0102_0304};

  initial begin
    int   a, a2, vi;
    logic r, exp_rr;
    exp_t e;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_be0 = '0;
    rsp_ready = 1'b1;
    rsp_ready0 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst_n = 1'b1;

    // Full-word store then read back.
    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b1, a);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, a);
    // Partial byte-enable merge: be=0101 replaces bytes 0 and 2.
    do_req(1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'h0, 1'b0, 1'b1, a);
    do_req(1'b1, 32'h20, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0, 1'b1, a);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0, 1'b1, a);
    // Errors: misaligned, out of range; the out-of-range store must not alias onto word 0.
    do_req(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 1'b1, a);
    do_req(1'b0, 32'h22, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, a);
    do_req(1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, a);
    do_req(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1'b1, a);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b1, a);
    // Store with no byte enables is acknowledged and changes nothing.
    do_req(1'b1, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, a);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, a);
    drain2();

    // Back-pressure: hold rsp_ready low in RESP while a second request waits.
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0, 1'b1, a);
    fork
      do_req(1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b1, a2);
      begin
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        if (!rsp_valid) flag("hold_no_rsp");
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    chk("accept_after_hs", a2, hs_edge2 + 1);
    drain2();

    // Zero wait states, back-to-back requests with req_valid held high.
    @(posedge clk);
    #1;
    vi = 0;
    req_valid0 = 1'b1; req_we0 = v_we[0]; req_addr0 = v_addr[0]; req_wdata0 = v_data[0]; req_be0 = 4'hF;
    exp_rr = 1'b1;
    for (int k = 0; k < 40 && vi < 5; k++) begin
      @(negedge clk);
      r = req_ready0;
      chk("req_ready0_pattern", {31'd0, r}, {31'd0, exp_rr});
      exp_rr = ~exp_rr;
      @(posedge clk);
      #1;
      if (r) begin
        e.rdata = v_exp[vi];
        e.err   = 1'b0;
        e.due   = cyc;
        q0.push_back(e);
        vi++;
        if (vi < 5) begin
          req_we0 = v_we[vi]; req_addr0 = v_addr[vi]; req_wdata0 = v_data[vi];
        end else begin
          req_valid0 = 1'b0;
        end
      end
    end
    req_valid0 = 1'b0;
    if (vi < 5) flag("ws0_timeout");
    for (int i = 0; i < 20 && q0.size() > 0; i++) @(negedge clk);
    if (q0.size() > 0) flag("drain0_timeout");

    // Reset during WAIT of a store: nothing is written and no response appears.
    do_req(1'b1, 32'h30, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1, a);
    drain2();
    do_req(1'b1, 32'h30, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1'b0, a);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("postrst_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    do_req(1'b0, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, a);
    drain2();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
